// File: rtl/sram_controller.sv
// sram_controller
//   Bridges the pipeline MEM stage to a 64-bit-wide SRAM that holds 32-bit
//   words. Converts a byte address to an SRAM word address, holds the SRAM
//   for WAIT_CYCLES cycles per access and stalls the pipeline (ready low)
//   until the access completes. On a read, selects the addressed 32-bit half
//   of the 64-bit data bus.
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     rd_en, wr_en      level-sensitive requests (both high -> write)
//     address           byte address
//     write_data        store data
//     read_data         registered load data
//     ready             1 = pipeline may advance (only combinational output)
//     SRAM_ADDR         SRAM word address (holds outside ACCESS)
//     SRAM_WE_N         SRAM write enable, active low
//     SRAM_DQ           SRAM data bus, driven only during a write ACCESS
module sram_controller #(
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [16:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  inout  wire  [63:0] SRAM_DQ
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [16:0] addr_q, addr_d;
  logic        we_n_q, we_n_d;

  logic        req;
  logic [16:0] word_addr;

  assign req = rd_en | wr_en;
  // Out-of-range addresses simply wrap modulo 2^17 words.
  assign word_addr = 17'((address - 32'(BASE_ADDR)) >> 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    we_n_d  = we_n_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACCESS;
          cnt_d   = CNT_LOAD;
          is_wr_d = wr_en;      // write wins when both are requested
          wdata_d = write_data;
          addr_d  = word_addr;
          we_n_d  = !wr_en;     // registered so WE_N is low for every ACCESS cycle
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          we_n_d  = 1'b1;
          // Odd word addresses live in the upper half of the bus.
          if (!is_wr_q)
            rdata_d = addr_q[0] ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      we_n_q  <= we_n_d;
    end
  end

  assign SRAM_DQ   = (state_q == ACCESS && is_wr_q) ? {32'b0, wdata_q} : 64'bz;
  assign ready     = (state_q == IDLE && !req) || (state_q == DONE);
  assign read_data = rdata_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

  localparam int W0 = 5;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst = 1'b1;

  // default-parameter instance
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdat = '0;
  logic [31:0] rdata;
  logic        rdy, we_n;
  logic [16:0] sa;
  wire  [63:0] dq;

  sram_controller u0 (
    .clk(clk), .rst(rst), .rd_en(rd), .wr_en(wr), .address(addr),
    .write_data(wdat), .read_data(rdata), .ready(rdy), .SRAM_ADDR(sa),
    .SRAM_WE_N(we_n), .SRAM_DQ(dq)
  );

  // WAIT_CYCLES=1 instance, read-only stimulus
  logic        rd1 = 1'b0;
  logic        wr1 = 1'b0;
  logic [31:0] addr1 = '0;
  logic [31:0] wdat1 = '0;
  logic [31:0] rdata1;
  logic        rdy1, we_n1;
  logic [16:0] sa1;
  wire  [63:0] dq1;

  sram_controller #(.WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(addr1),
    .write_data(wdat1), .read_data(rdata1), .ready(rdy1), .SRAM_ADDR(sa1),
    .SRAM_WE_N(we_n1), .SRAM_DQ(dq1)
  );

  // SRAM model for u0: 32-bit words, odd words presented on the upper half.
  // The unselected half carries the inverse so a wrong selection shows up.
  logic [31:0] mem [16];
  logic        oe = 1'b0;
  wire  [31:0] mw = mem[sa[3:0]];
  assign dq = (oe && we_n) ? (sa[0] ? {mw, ~mw} : {~mw, mw}) : 64'bz;
  always @(posedge clk) if (!rst && !we_n) mem[sa[3:0]] <= dq[31:0];

  // Fixed-pattern SRAM for u1
  assign dq1 = we_n1 ? {32'hBBBB0001, 32'hAAAA0000} : 64'bz;

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_z(input string nm, input logic [63:0] act);
    tests++;
    // undriven bus reads as z in 4-state simulators, 0 in 2-state ones
    if (!(act === 64'bz || act === 64'b0)) begin
      fails++;
      $display("FAIL %s: got %h expected high-Z", nm, act);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [16:0] exp_sa;
    logic [31:0] exp_rd;   // read_data expected in DONE
  } vec_t;

  // One full transaction on u0; checks latency, address, WE_N, write data, read data.
  task automatic xact(input vec_t v, input string nm);
    int low, wel;
    logic [16:0] sa_seen;
    logic [63:0] dq_seen;
    @(negedge clk);
    rd = v.rd; wr = v.wr; addr = v.addr; wdat = v.wdata;
    #1;
    low = 0; wel = 0; sa_seen = '0; dq_seen = '0;
    while (!rdy && low < 40) begin
      low++;
      if (low > 1) begin            // first low cycle is the IDLE request cycle
        sa_seen = sa;
        if (!we_n) begin wel++; dq_seen = dq; end
      end
      @(negedge clk); #1;
    end
    chk({nm, " ready_low"}, 64'(low), 64'(1 + W0));
    chk({nm, " sram_addr"}, 64'(sa_seen), 64'(v.exp_sa));
    chk({nm, " we_low"},    64'(wel), v.wr ? 64'(W0) : 64'd0);
    if (v.wr) chk({nm, " dq_write"}, dq_seen, {32'b0, v.wdata});
    chk({nm, " read_data"}, 64'(rdata), 64'(v.exp_rd));
    chk({nm, " done_we_n"}, 64'(we_n), 64'd1);
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic xact1(input logic [31:0] a, input logic [16:0] esa,
                       input logic [31:0] erd, input string nm);
    int low;
    logic [16:0] sa_seen;
    @(negedge clk);
    rd1 = 1'b1; addr1 = a;
    #1;
    low = 0; sa_seen = '0;
    while (!rdy1 && low < 40) begin
      low++;
      if (low > 1) sa_seen = sa1;
      @(negedge clk); #1;
    end
    chk({nm, " ready_low"}, 64'(low), 64'd2);
    chk({nm, " sram_addr"}, 64'(sa_seen), 64'(esa));
    chk({nm, " read_data"}, 64'(rdata1), 64'(erd));
    rd1 = 1'b0;
  endtask

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 17'h0,     32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'd1024, 32'h11111111, 17'h0,     32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'd1028, 32'h22222222, 17'h1,     32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'd1028, 32'h0,        17'h1,     32'h22222222};
    vecs[4]  = '{1'b1, 1'b0, 32'd1024, 32'h0,        17'h0,     32'h11111111};
    vecs[5]  = '{1'b1, 1'b1, 32'd1032, 32'h5A5A5A5A, 17'h2,     32'h11111111};
    vecs[6]  = '{1'b1, 1'b0, 32'd1032, 32'h0,        17'h2,     32'h5A5A5A5A};
    vecs[7]  = '{1'b0, 1'b1, 32'd1036, 32'hCAFEF00D, 17'h3,     32'h5A5A5A5A};
    vecs[8]  = '{1'b1, 1'b0, 32'd1036, 32'h0,        17'h3,     32'hCAFEF00D};
    vecs[9]  = '{1'b0, 1'b1, 32'd1020, 32'h0BADF00D, 17'h1FFFF, 32'hCAFEF00D};
    vecs[10] = '{1'b1, 1'b0, 32'd1020, 32'h0,        17'h1FFFF, 32'h0BADF00D};

    // reset, no requests
    repeat (2) @(negedge clk);
    #1;
    chk("rst ready",     64'(rdy), 64'd1);
    chk("rst we_n",      64'(we_n), 64'd1);
    chk_z("rst dq", dq);
    chk("rst read_data", 64'(rdata), 64'd0);
    chk("rst sram_addr", 64'(sa), 64'd0);
    chk("rst ready_w1",  64'(rdy1), 64'd1);
    rst = 1'b0;
    oe  = 1'b1;

    for (int i = 0; i < 11; i++) begin
      xact(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        @(negedge clk);
        chk("vec0 idle_ready", 64'(rdy), 64'd1);
        chk("vec0 mem0", 64'(mem[0]), 64'hDEADBEEF);
      end
    end

    // reset on the 3rd ACCESS cycle of a write
    @(negedge clk);
    wr = 1'b1; addr = 32'd1040; wdat = 32'h77777777;    // IDLE request cycle
    repeat (3) @(negedge clk);                          // now in ACCESS #3
    #1;
    chk("mid we_n", 64'(we_n), 64'd0);
    rst = 1'b1; wr = 1'b0;
    @(negedge clk);
    oe = 1'b0;
    #1;
    chk("mid_rst ready",     64'(rdy), 64'd1);
    chk("mid_rst we_n",      64'(we_n), 64'd1);
    chk_z("mid_rst dq", dq);
    chk("mid_rst read_data", 64'(rdata), 64'd0);
    rst = 1'b0;
    oe  = 1'b1;
    xact('{1'b1, 1'b0, 32'd1028, 32'h0, 17'h1, 32'h22222222}, "post_rst");

    // WAIT_CYCLES = 1
    xact1(32'd1024 + 32'd4 * 32'd131072, 17'h0, 32'hAAAA0000, "w1 wrap");
    xact1(32'd1028, 17'h1, 32'hBBBB0001, "w1 odd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
